// File: rtl/flasher_sequencer.sv
// -----------------------------------------------------------------------------
// flasher_sequencer
//   Front-end controller for the 16-LED bound flasher. It:
//     - generates the flasher step clock-enable (step_en),
//     - synchronises and debounces the raw flick button,
//     - turns each press (or an auto-restart request) into a flick pulse that
//       spans exactly one step_en,
//     - tracks each flasher run from start until all LEDs are off, counts
//       completed runs and flags runs that never light any LED.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   btn_raw    in   1      raw flick pushbutton, asynchronous, active-high
//   auto_mode  in   1      1 = restart the sequence automatically whenever idle
//   leds       in   16     flasher LED outputs (observed only)
//   step_en    out  1      one-clk pulse every TICK_DIV clks (decoded from prescaler)
//   flick      out  1      flick to flasher, high for exactly one step period
//   busy       out  1      high while a run is in progress or completing
//   run_done   out  1      one-clk pulse on each completed run
//   run_count  out  CNT_W  completed runs, saturating
// -----------------------------------------------------------------------------
module flasher_sequencer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned START_TO = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             auto_mode,
  input  logic [15:0]      leds,
  output logic             step_en,
  output logic             flick,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] run_count
);

  localparam int unsigned PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam int unsigned TO_W = (START_TO > 1) ? $clog2(START_TO + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PC_W-1:0]  r_pcnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_press_pend;
  logic             r_flick;
  state_t           r_state;
  logic             r_seen_on;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_busy;
  logic             r_run_done;
  logic [CNT_W-1:0] r_run_count;

  logic             w_step_en;
  logic             w_db_diff;
  logic             w_db_fire;
  logic             w_press_edge;
  logic             w_auto_req;
  logic             w_consume;
  logic             w_leds_on;
  state_t           w_state_nxt;
  logic             w_seen_on_nxt;
  logic [TO_W-1:0]  w_to_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_run_done_nxt;

  // Step enable decoded straight from the prescaler.
  assign w_step_en = (r_pcnt == PC_W'(TICK_DIV - 1));

  // Free-running prescaler, wraps on step_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (w_step_en) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PC_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the level moves only after DEB_CYC consecutive differing clks;
  // a single matching clk (bounce) restarts the count.
  assign w_db_diff    = r_sync2 ^ r_btn_db;
  assign w_db_fire    = w_db_diff && (r_db_cnt == DB_W'(DEB_CYC - 1));
  assign w_press_edge = w_db_fire && r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (!w_db_diff) begin
      r_db_cnt <= '0;
    end else if (w_db_fire) begin
      r_btn_db <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // A pend (or auto request) is consumed only on step_en and never while a
  // flick is already in flight, so each flick spans exactly one step_en.
  assign w_auto_req = (r_state == ST_IDLE) && auto_mode && !r_flick;
  assign w_consume  = w_step_en && (r_press_pend || w_auto_req) && !r_flick;

  // Press pend: a new edge in the consume cycle wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press_pend <= 1'b0;
    end else if (w_press_edge) begin
      r_press_pend <= 1'b1;
    end else if (w_consume) begin
      r_press_pend <= 1'b0;
    end
  end

  // Flick rises after the consume and drops after the next step_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flick <= 1'b0;
    end else if (w_consume) begin
      r_flick <= 1'b1;
    end else if (r_flick && w_step_en) begin
      r_flick <= 1'b0;
    end
  end

  assign w_leds_on = (leds != 16'h0000);

  // Run tracker state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run tracker next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_seen_on_nxt  = r_seen_on;
    w_to_cnt_nxt   = r_to_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_consume) begin
          w_state_nxt   = ST_RUN;
          w_seen_on_nxt = 1'b0;
          w_to_cnt_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (w_leds_on) begin
          w_seen_on_nxt = 1'b1;
        end
        if (w_step_en && !w_leds_on) begin
          if (r_seen_on) begin
            w_state_nxt = ST_DONE;
          end else if (r_to_cnt == TO_W'(START_TO - 1)) begin
            // Flasher never lit: abandon the run silently.
            w_state_nxt  = ST_IDLE;
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt     = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
    w_run_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Run tracker datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen_on   <= 1'b0;
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_run_done  <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_seen_on  <= w_seen_on_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_run_done <= w_run_done_nxt;
      if (w_run_done_nxt && (r_run_count != {CNT_W{1'b1}})) begin
        r_run_count <= r_run_count + CNT_W'(1);
      end
    end
  end

  assign step_en   = w_step_en;
  assign flick     = r_flick;
  assign busy      = r_busy;
  assign run_done  = r_run_done;
  assign run_count = r_run_count;

endmodule

// File: tb/tb_flasher_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flasher_sequencer
//   Self-checking bench for flasher_sequencer. Flick rise cycles and run_done
//   events are predicted into queues when stimulus is driven and checked by a
//   negedge monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_flasher_sequencer;

  localparam int TB_TICK = 4;
  localparam int TB_DEB  = 3;
  localparam int TB_TO   = 4;
  localparam int TB_CW   = 4;
  localparam int CNT_MAX = (1 << TB_CW) - 1;

  logic             clk;
  logic             rst;
  logic             btn_raw;
  logic             auto_mode;
  logic [15:0]      leds;
  logic             step_en;
  logic             flick;
  logic             busy;
  logic             run_done;
  logic [TB_CW-1:0] run_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int exp_count = 0;
  int flick_q[$];
  int done_cyc_q[$];
  int done_cnt_q[$];

  flasher_sequencer #(
    .TICK_DIV (TB_TICK),
    .DEB_CYC  (TB_DEB),
    .START_TO (TB_TO),
    .CNT_W    (TB_CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .auto_mode (auto_mode),
    .leds      (leds),
    .step_en   (step_en),
    .flick     (flick),
    .busy      (busy),
    .run_done  (run_done),
    .run_count (run_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since reset release; prescaler model is cyc % TB_TICK.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: flick rise cycle/width and run_done cycle/count.
  initial begin : monitor
    logic f_prev;
    int   f_w;
    int   e_cyc;
    int   e_cnt;
    f_prev = 1'b0;
    f_w    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        f_prev = 1'b0;
        f_w    = 0;
      end else begin
        if (flick && !f_prev) begin
          n_tests++;
          if (flick_q.size() == 0) begin
            n_fail++;
            $display("FAIL flick_rise: unexpected flick at cyc %0d", cyc);
          end else begin
            e_cyc = flick_q.pop_front();
            if (cyc !== e_cyc) begin
              n_fail++;
              $display("FAIL flick_rise: got cyc %0d expected cyc %0d", cyc, e_cyc);
            end
          end
        end
        if (flick) begin
          f_w++;
        end else if (f_prev) begin
          n_tests++;
          if (f_w !== TB_TICK) begin
            n_fail++;
            $display("FAIL flick_width: got %0d clks expected %0d", f_w, TB_TICK);
          end
          f_w = 0;
        end
        f_prev = flick;
        if (run_done) begin
          n_tests++;
          if (done_cyc_q.size() == 0) begin
            n_fail++;
            $display("FAIL run_done: unexpected pulse at cyc %0d", cyc);
          end else begin
            e_cyc = done_cyc_q.pop_front();
            e_cnt = done_cnt_q.pop_front();
            if (cyc !== e_cyc || run_count !== TB_CW'(e_cnt)) begin
              n_fail++;
              $display("FAIL run_done: got cyc %0d count %0d expected cyc %0d count %0d",
                       cyc, run_count, e_cyc, e_cnt);
            end
          end
        end
      end
    end
  end

  function automatic int next_rise(input int from);
    int m;
    m = from;
    while (m % TB_TICK != TB_TICK - 1) m++;
    return m + 1;
  endfunction

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  // Advance to the cycle in which step_en is high.
  task automatic goto_step();
    do at_pos(); while (cyc % TB_TICK != TB_TICK - 1);
  endtask

  task automatic wait_flick(input logic level, input string what);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (flick === level) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: flick never reached %0b within 64 clks", what, level);
    end
  endtask

  task automatic press(output int n);
    at_pos();
    btn_raw = 1'b1;
    n = cyc;
    flick_q.push_back(next_rise(n + TB_DEB + 2));
  endtask

  task automatic test_reset();
    logic [7:0] got;
    repeat (3) @(negedge clk);
    got = {step_en, flick, busy, run_done, run_count};
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 00", got);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_prescaler();
    logic [7:0] got;
    logic [7:0] exp;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      got = {step_en, flick, busy, run_done, run_count};
      exp = {(i % TB_TICK == TB_TICK - 1), 3'b000, 4'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL prescaler clk %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_debounce_press();
    int n;
    int db_at;
    at_pos(); btn_raw = 1'b0;
    at_pos(); btn_raw = 1'b1;
    at_pos(); btn_raw = 1'b0;
    at_pos(); btn_raw = 1'b1;
    n = cyc;
    flick_q.push_back(next_rise(n + TB_DEB + 2));
    db_at = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (dut.r_btn_db === 1'b1) begin
        db_at = cyc;
        break;
      end
    end
    n_tests++;
    if (db_at !== n + TB_DEB + 2) begin
      n_fail++;
      $display("FAIL debounce_rise: got cyc %0d expected cyc %0d", db_at, n + TB_DEB + 2);
    end
    wait_flick(1'b1, "press_flick_rise");
    wait_flick(1'b0, "press_flick_fall");
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL press_busy: got %0b expected 1", busy);
    end
    at_pos(); btn_raw = 1'b0;
  endtask

  task automatic test_run_complete();
    int s;
    goto_step(); leds = 16'h0001;
    goto_step(); leds = 16'h003F;
    goto_step(); leds = 16'h0000;
    s = cyc;
    exp_count = (exp_count == CNT_MAX) ? CNT_MAX : exp_count + 1;
    done_cyc_q.push_back(s + 1);
    done_cnt_q.push_back(exp_count);
    repeat (4) @(negedge clk);
    n_tests++;
    if ({busy, run_count} !== {1'b0, TB_CW'(exp_count)} || done_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_complete: got busy %0b count %0d pending %0d expected busy 0 count %0d pending 0",
               busy, run_count, done_cyc_q.size(), exp_count);
    end
  endtask

  task automatic test_start_timeout();
    int n;
    int m;
    press(n);
    m = next_rise(n + TB_DEB + 2) - 1;
    wait_flick(1'b1, "timeout_flick_rise");
    at_pos(); btn_raw = 1'b0;
    for (int k = 0; k < 64 && cyc != m + 4 * TB_TO; k++) @(negedge clk);
    n_tests++;
    if (cyc !== m + 4 * TB_TO || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_last_step: got cyc %0d busy %0b expected cyc %0d busy 1",
               cyc, busy, m + 4 * TB_TO);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, run_done, run_count} !== {2'b00, TB_CW'(exp_count)}) begin
      n_fail++;
      $display("FAIL timeout_abort: got busy %0b done %0b count %0d expected busy 0 done 0 count %0d",
               busy, run_done, run_count, exp_count);
    end
  endtask

  task automatic test_auto_restart();
    int  s;
    logic last;
    at_pos();
    auto_mode = 1'b1;
    flick_q.push_back(next_rise(cyc));
    for (int i = 0; i < 22; i++) begin
      last = (i == 21);
      wait_flick(1'b1, "auto_flick_rise");
      goto_step(); leds = 16'h0001;
      goto_step(); leds = 16'h003F;
      if (last) auto_mode = 1'b0;
      goto_step(); leds = 16'h0000;
      s = cyc;
      exp_count = (exp_count == CNT_MAX) ? CNT_MAX : exp_count + 1;
      done_cyc_q.push_back(s + 1);
      done_cnt_q.push_back(exp_count);
      if (!last) flick_q.push_back(next_rise(s + 2));
    end
    repeat (24) @(negedge clk);
    n_tests++;
    if (flick_q.size() != 0 || done_cyc_q.size() != 0 ||
        run_count !== TB_CW'(CNT_MAX) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_saturate: got count %0d busy %0b pending %0d/%0d expected count %0d busy 0 pending 0/0",
               run_count, busy, flick_q.size(), done_cyc_q.size(), CNT_MAX);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [7:0] got;
    press(n);
    wait_flick(1'b1, "reset_flick_rise");
    at_pos();
    rst     = 1'b0;
    btn_raw = 1'b0;
    #1;
    got = {flick, busy, run_done, step_en, run_count};
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h expected 00", got);
    end
    at_pos();
    rst = 1'b1;
    exp_count = 0;
    for (int k = 1; k <= 4; k++) begin
      at_pos();
      n_tests++;
      if ({step_en, busy, run_count} !== {(k == TB_TICK - 1), 1'b0, 4'h0}) begin
        n_fail++;
        $display("FAIL reset_prescaler clk %0d: got step %0b busy %0b count %0d expected step %0b busy 0 count 0",
                 k, step_en, busy, run_count, (k == TB_TICK - 1));
      end
    end
    repeat (12) @(negedge clk);
    n_tests++;
    if (flick_q.size() != 0 || done_cyc_q.size() != 0 || flick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain: got pending %0d/%0d flick %0b expected 0/0 flick 0",
               flick_q.size(), done_cyc_q.size(), flick);
    end
  endtask

  initial begin
    rst       = 1'b0;
    btn_raw   = 1'b0;
    auto_mode = 1'b0;
    leds      = 16'h0000;
    test_reset();
    test_prescaler();
    test_debounce_press();
    test_run_complete();
    test_start_timeout();
    test_auto_restart();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
